fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage core: owns the fetch PC, drives the instruction-memory request/response handshake, and holds the IF/ID pipeline register.
- Consumes `stall` from the hazard detection unit (load-use hold) and the branch/jump redirect from EX.
- Feeds the decode stage with `pc_id`, `pc4_id`, `inst_id` and `valid_id`.
- At most one memory request is outstanding at any time.

---
 rtl/core_pkg.sv | 7 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core-wide constants and the fetch FSM state encoding.
package core_pkg;
  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel; master = fetch stage, slave = memory.
interface fetch_stage_if #(parameter int XLEN = core_pkg::XLEN);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (output imem_req_valid, imem_req_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_req_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds.
module if_id_reg #(
  parameter int          XLEN     = core_pkg::XLEN,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     inst_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [31:0]     inst
);
  // a flushed entry keeps its pc/pc4 so only valid and inst carry meaning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
      pc4   <= XLEN'(4);
    end else if (flush) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= inst_in;
      pc    <= pc_in;
      pc4   <= pc_in + XLEN'(4);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: fetch PC, single-outstanding imem handshake, stall hold buffer, IF/ID.
module fetch_stage #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = core_pkg::NOP_INST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [XLEN-1:0]    br_target,
  fetch_stage_if.master      imem,
  output logic               valid_id,
  output logic [XLEN-1:0]    pc_id,
  output logic [XLEN-1:0]    pc4_id,
  output logic [31:0]        inst_id
);
  import core_pkg::*;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, br_pc;
  logic [31:0]     hold_data, deliver_data;
  logic            hold_valid, accept, deliver, capture, bubble, req_valid;

  assign accept              = req_valid & imem.imem_req_ready;
  assign br_pc               = br_target & ~XLEN'(3);
  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc;
  assign bubble              = br_taken | (~stall & ~deliver);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (accept) state_nxt = br_taken ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (br_taken)                 state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
        else if (imem.imem_rsp_valid) state_nxt = stall ? S_HOLD : S_REQ;
      end
      S_HOLD: if (br_taken || !stall) state_nxt = S_REQ;
      S_DROP: if (imem.imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid    = 1'b0;
    deliver      = 1'b0;
    capture      = 1'b0;
    deliver_data = imem.imem_rsp_data;
    unique case (state)
      S_REQ:  req_valid = 1'b1;
      S_WAIT: if (imem.imem_rsp_valid && !br_taken) begin
        deliver = ~stall;
        capture = stall;
      end
      S_HOLD: if (hold_valid && !br_taken && !stall) begin
        deliver      = 1'b1;
        deliver_data = hold_data;
      end
      default: ;
    endcase
  end

  // redirect always wins over a delivery or capture in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      hold_valid <= 1'b0;
      hold_data  <= NOP_INST;
    end else begin
      if (br_taken)     fetch_pc <= br_pc;
      else if (deliver) fetch_pc <= fetch_pc + XLEN'(4);
      if (br_taken || deliver) hold_valid <= 1'b0;
      else if (capture) begin
        hold_valid <= 1'b1;
        hold_data  <= imem.imem_rsp_data;
      end
    end
  end

  if_id_reg #(.XLEN(XLEN), .NOP_INST(NOP_INST)) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (deliver),
    .flush  (bubble),
    .pc_in  (fetch_pc),
    .inst_in(deliver_data),
    .valid  (valid_id),
    .pc     (pc_id),
    .pc4    (pc4_id),
    .inst   (inst_id)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
module tb_fetch_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_taken;
  logic [31:0] br_target;
  logic        valid_id;
  logic [31:0] pc_id, pc4_id, inst_id;
  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;

  fetch_stage_if imem();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INST(32'h13)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem(imem.master), .valid_id(valid_id), .pc_id(pc_id), .pc4_id(pc4_id), .inst_id(inst_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0010_0093 : (a ^ 32'hABCD_0000);
  endfunction

  // memory: response 'lat' cycles after acceptance, never backpressured
  initial begin
    logic pend, acc;
    int cnt;
    logic [31:0] paddr, a;
    pend = 0; cnt = 0; paddr = 0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      if (imem.imem_rsp_valid && rst_n) begin
        total++;
        if (dut.state == S_IDLE || dut.state == S_REQ) begin
          $display("FAIL protocol: rsp_valid seen in state %0d, required WAIT/HOLD/DROP", dut.state);
          bad++;
        end
      end
      acc = imem.imem_req_valid && imem.imem_req_ready;
      a   = imem.imem_req_addr;
      #1;
      imem.imem_rsp_valid = 1'b0;
      if (!rst_n) pend = 0;
      else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = inst_at(paddr); pend = 0;
          end
        end
        if (acc) begin
          if (lat <= 1) begin
            imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = inst_at(a);
          end else begin
            pend = 1; cnt = lat - 1; paddr = a;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst_n = 0; tick(); tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b0, 32'h0, 32'h4, 32'h13}) begin
      $display("FAIL reset_ifid: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b0, 32'h0, 32'h4, 32'h13}); bad++; end
    total++; if (imem.imem_req_valid !== 1'b0) begin
      $display("FAIL reset_req: got %b want 0", imem.imem_req_valid); bad++; end
    rst_n = 1;
    total++; if (imem.imem_req_valid !== 1'b0) begin
      $display("FAIL idle_cycle: got %b want 0", imem.imem_req_valid); bad++; end
    tick();
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL first_req: got %b/%h want 1/00000000", imem.imem_req_valid, imem.imem_req_addr); bad++; end
    tick();
    total++; if ({imem.imem_req_valid, valid_id} !== 2'b00) begin
      $display("FAIL wait_state: got %b%b want 00", imem.imem_req_valid, valid_id); bad++; end
    tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b1, 32'h0, 32'h4, 32'h0010_0093}) begin
      $display("FAIL first_deliver: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b1, 32'h0, 32'h4, 32'h0010_0093}); bad++; end
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h4}) begin
      $display("FAIL second_req: got %b/%h want 1/00000004", imem.imem_req_valid, imem.imem_req_addr); bad++; end
  endtask

  task automatic test_stall_hold();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({valid_id, pc_id, pc4_id, inst_id, imem.imem_req_valid} !== {1'b1, 32'h0, 32'h4, 32'h0010_0093, 1'b0}) begin
        $display("FAIL stall_hold[%0d]: got %h want %h", i, {valid_id, pc_id, pc4_id, inst_id, imem.imem_req_valid},
                 {1'b1, 32'h0, 32'h4, 32'h0010_0093, 1'b0}); bad++; end
    end
    stall = 0; tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b1, 32'h4, 32'h8, 32'hABCD_0004}) begin
      $display("FAIL hold_release: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b1, 32'h4, 32'h8, 32'hABCD_0004}); bad++; end
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h8}) begin
      $display("FAIL hold_next_req: got %b/%h want 1/00000008", imem.imem_req_valid, imem.imem_req_addr); bad++; end
  endtask

  task automatic test_redirect_wait();
    lat = 3; tick();
    br_taken = 1; br_target = 32'h80; tick(); br_taken = 0;
    total++; if ({valid_id, pc_id, pc4_id, inst_id, imem.imem_req_valid} !== {1'b0, 32'h4, 32'h8, 32'h13, 1'b0}) begin
      $display("FAIL redirect_flush: got %h want %h", {valid_id, pc_id, pc4_id, inst_id, imem.imem_req_valid},
               {1'b0, 32'h4, 32'h8, 32'h13, 1'b0}); bad++; end
    tick();
    total++; if ({imem.imem_req_valid, valid_id} !== 2'b00) begin
      $display("FAIL drop_wait: got %b%b want 00", imem.imem_req_valid, valid_id); bad++; end
    lat = 1; tick();
    total++; if ({imem.imem_req_valid, imem.imem_req_addr, valid_id} !== {1'b1, 32'h80, 1'b0}) begin
      $display("FAIL drop_discard: got %b/%h/%b want 1/00000080/0", imem.imem_req_valid, imem.imem_req_addr, valid_id); bad++; end
    tick(); tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b1, 32'h80, 32'h84, 32'hABCD_0080}) begin
      $display("FAIL target_deliver: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b1, 32'h80, 32'h84, 32'hABCD_0080}); bad++; end
  endtask

  task automatic test_br_stall();
    br_taken = 1; br_target = 32'h83; stall = 1; tick(); br_taken = 0; stall = 0;
    total++; if ({valid_id, inst_id, imem.imem_req_valid, imem.imem_req_addr} !== {1'b0, 32'h13, 1'b0, 32'h80}) begin
      $display("FAIL br_over_stall: got %h want %h", {valid_id, inst_id, imem.imem_req_valid, imem.imem_req_addr},
               {1'b0, 32'h13, 1'b0, 32'h80}); bad++; end
    tick();
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h80}) begin
      $display("FAIL aligned_req: got %b/%h want 1/00000080", imem.imem_req_valid, imem.imem_req_addr); bad++; end
    tick(); tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b1, 32'h80, 32'h84, 32'hABCD_0080}) begin
      $display("FAIL aligned_deliver: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b1, 32'h80, 32'h84, 32'hABCD_0080}); bad++; end
  endtask

  task automatic test_wrap();
    imem.imem_req_ready = 0; tick();
    total++; if ({imem.imem_req_valid, imem.imem_req_addr, valid_id} !== {1'b1, 32'h84, 1'b0}) begin
      $display("FAIL req_hold_notready: got %b/%h/%b want 1/00000084/0", imem.imem_req_valid, imem.imem_req_addr, valid_id); bad++; end
    br_taken = 1; br_target = 32'hFFFF_FFFC; tick(); br_taken = 0; imem.imem_req_ready = 1;
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      $display("FAIL redirect_in_req: got %b/%h want 1/fffffffc", imem.imem_req_valid, imem.imem_req_addr); bad++; end
    tick(); tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h5432_FFFC}) begin
      $display("FAIL wrap_deliver: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h5432_FFFC}); bad++; end
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL wrap_req: got %b/%h want 1/00000000", imem.imem_req_valid, imem.imem_req_addr); bad++; end
  endtask

  task automatic test_reset_mid();
    lat = 3; tick();
    total++; if (imem.imem_req_valid !== 1'b0) begin
      $display("FAIL mid_wait: got %b want 0", imem.imem_req_valid); bad++; end
    #1 rst_n = 0; #1;
    total++; if ({valid_id, pc_id, pc4_id, inst_id, imem.imem_req_valid} !== {1'b0, 32'h0, 32'h4, 32'h13, 1'b0}) begin
      $display("FAIL async_reset: got %h want %h", {valid_id, pc_id, pc4_id, inst_id, imem.imem_req_valid},
               {1'b0, 32'h0, 32'h4, 32'h13, 1'b0}); bad++; end
    lat = 1; tick(); tick(); rst_n = 1; tick();
    total++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL restart_req: got %b/%h want 1/00000000", imem.imem_req_valid, imem.imem_req_addr); bad++; end
    tick(); tick();
    total++; if ({valid_id, pc_id, pc4_id, inst_id} !== {1'b1, 32'h0, 32'h4, 32'h0010_0093}) begin
      $display("FAIL restart_deliver: got %h want %h", {valid_id, pc_id, pc4_id, inst_id}, {1'b1, 32'h0, 32'h4, 32'h0010_0093}); bad++; end
  endtask

  initial begin
    rst_n = 0; stall = 0; br_taken = 0; br_target = 32'h0;
    imem.imem_req_ready = 1;
    test_reset();
    test_stall_hold();
    test_redirect_wait();
    test_br_stall();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
